// File: rtl/aes_decrypt_iter.sv
// Purpose : iterative AES-128 inverse cipher, one key-expansion step or one round per clock.
// Latency : accept edge T -> out_valid after edge T+20 (T+10 when the expanded key is reused).
// Backpr. : out_ready low only holds DONE; in_ready is high in IDLE only.
//
// Ports   : clk, rst_n (async active-low)
//           in_valid / in_ready / cipher_text_128 / cipher_key_128  - ciphertext+key stream in
//           out_valid / out_ready / plan_text_128                   - registered plaintext out
//           busy                                                    - high during KEXP or ROUND
// Option  : define AES_DEC_KEY_CACHE_EN to skip key expansion when the key matches the last
//           fully expanded key.
module aes_decrypt_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_text_128,
  input  logic [127:0] cipher_key_128,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plan_text_128,
  output logic         busy
);

  // Byte 0 of each table is in the top bits, so entry x sits at bit offset 8*(255-x).
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_ROUND, S_DONE} state_t;

  state_t              r_fsm;
  state_t              w_fsm_nxt;
  logic [127:0]        r_st;
  logic [10:0][127:0]  r_rk;
  logic [3:0]          r_kidx;      // index of the round key produced on the next KEXP edge
  logic [3:0]          r_rnd;       // round key used by the current ROUND cycle
  logic [127:0]        r_pt;
  logic                r_out_vld;
  logic                w_hit;
  logic [127:0]        w_rk_new;
  logic [127:0]        w_round_ark;
  logic [127:0]        w_round_out;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward key-schedule step: four new words from the previous round key.
  function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = prev;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // InvShiftRows followed by InvSubBytes; byte r+4c is row r, column c.
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
  endfunction

`ifdef AES_DEC_KEY_CACHE_EN
  // rk0 doubles as the cached key; the valid bit says rk1..rk10 belong to it.
  logic r_cache_vld;
  assign w_hit = r_cache_vld && (cipher_key_128 == r_rk[0]);
`else
  assign w_hit = 1'b0;
`endif

  assign w_rk_new    = key_step(r_rk[r_kidx - 4'd1], rcon(r_kidx));
  assign w_round_ark = inv_sub_shift(r_st) ^ r_rk[r_rnd];
  assign w_round_out = (r_rnd == 4'd0) ? w_round_ark : inv_mix(w_round_ark);

  assign out_valid     = r_out_vld;
  assign plan_text_128 = r_pt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_nxt = w_hit ? S_ROUND : S_KEXP;
      end
      S_KEXP: begin
        busy = 1'b1;
        if (r_kidx == 4'd10) w_fsm_nxt = S_ROUND;
      end
      S_ROUND: begin
        busy = 1'b1;
        if (r_rnd == 4'd0) w_fsm_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= '0;
      r_rk      <= '0;
      r_kidx    <= '0;
      r_rnd     <= '0;
      r_pt      <= '0;
      r_out_vld <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      r_cache_vld <= 1'b0;
`endif
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            if (w_hit) begin
              r_st  <= cipher_text_128 ^ r_rk[10];
              r_rnd <= 4'd9;
            end else begin
              r_st    <= cipher_text_128;
              r_rk[0] <= cipher_key_128;
              r_kidx  <= 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
              // rk1..rk10 are about to be overwritten for the new key.
              r_cache_vld <= 1'b0;
`endif
            end
          end
        end
        S_KEXP: begin
          r_rk[r_kidx] <= w_rk_new;
          r_kidx       <= r_kidx + 4'd1;
          if (r_kidx == 4'd10) begin
            // Initial AddRoundKey uses rk10 as it is being produced.
            r_st  <= r_st ^ w_rk_new;
            r_rnd <= 4'd9;
`ifdef AES_DEC_KEY_CACHE_EN
            r_cache_vld <= 1'b1;
`endif
          end
        end
        S_ROUND: begin
          r_st <= w_round_out;
          if (r_rnd == 4'd0) begin
            r_pt      <= w_round_out;
            r_out_vld <= 1'b1;
          end else begin
            r_rnd <= r_rnd - 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) r_out_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
